// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH->ID->EX->[MEM]->[WB] with stall, memory
// ready/timeout handshake, halt state and a retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int RETIRE_W    = 32,
  parameter int MEM_TIMEOUT = 16,
  localparam int TO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          alusel,
  input  logic                stall_i,
  input  logic                mem_ready_i,
  input  logic                halt_req_i,
  output logic                pc_en,
  output logic                id_en,
  output logic                ex_en,
  output logic                mem_en,
  output logic                wb_en,
  output logic                jump_en,
  output logic                imm_en,
  output logic                expc_en,
  output logic                l_or_s,
  output logic [1:0]          wb_ctrl,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                mem_timeout_o,
  output logic [RETIRE_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                jump_q, jump_d;
  logic                imm_q, imm_d;
  logic                expc_q, expc_d;
  logic                l_or_s_q, l_or_s_d;
  logic [1:0]          wb_ctrl_q, wb_ctrl_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;

  always_comb begin
    state_d   = state_q;
    jump_d    = jump_q;
    imm_d     = imm_q;
    expc_d    = expc_q;
    l_or_s_d  = l_or_s_q;
    wb_ctrl_d = wb_ctrl_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    // A stalled cycle freezes every piece of sequencer state.
    if (!stall_i) begin
      case (state_q)
        S_FETCH: begin
          if (halt_req_i) begin
            state_d = S_HALT;
          end else begin
            state_d = S_ID;
            jump_d  = alusel[6];
          end
        end
        S_ID: state_d = S_EX;
        S_EX: begin
          imm_d  = alusel[5];
          expc_d = (alusel[2:1] == 2'b01);
          if (!alusel[0]) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else if (alusel[3]) begin
            state_d  = S_MEM;
            l_or_s_d = alusel[4];
            cnt_d    = '0;
          end else begin
            state_d   = S_WB;
            wb_ctrl_d = alusel[2:1];
          end
        end
        S_MEM: begin
          // Ready on the final permitted cycle still completes the access.
          if (mem_ready_i) begin
            if (alusel[4]) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d   = S_WB;
              wb_ctrl_d = alusel[2:1];
            end
          end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
            state_d   = S_HALT;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        S_WB: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        S_HALT: begin
          if (!halt_req_i && !timeout_q) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
    retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      jump_q    <= 1'b0;
      imm_q     <= 1'b0;
      expc_q    <= 1'b0;
      l_or_s_q  <= 1'b0;
      wb_ctrl_q <= 2'b00;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      jump_q    <= jump_d;
      imm_q     <= imm_d;
      expc_q    <= expc_d;
      l_or_s_q  <= l_or_s_d;
      wb_ctrl_q <= wb_ctrl_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  // A pending halt suppresses the fetch enable in the cycle it is taken.
  assign pc_en  = (state_q == S_FETCH) && !stall_i && !halt_req_i;
  assign id_en  = (state_q == S_ID)    && !stall_i;
  assign ex_en  = (state_q == S_EX)    && !stall_i;
  assign mem_en = (state_q == S_MEM)   && !stall_i;
  assign wb_en  = (state_q == S_WB)    && !stall_i;

  assign jump_en       = jump_q;
  assign imm_en        = imm_q;
  assign expc_en       = expc_q;
  assign l_or_s        = l_or_s_q;
  assign wb_ctrl       = wb_ctrl_q;
  assign state_o       = state_q;
  assign busy_o        = (state_q != S_HALT);
  assign mem_timeout_o = timeout_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one task per scenario, hand-computed
// cycle tables of stage enables and state, built with MEM_TIMEOUT=4.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  alusel;
  logic        stall_i, mem_ready_i, halt_req_i;
  logic        pc_en, id_en, ex_en, mem_en, wb_en;
  logic        jump_en, imm_en, expc_en, l_or_s;
  logic [1:0]  wb_ctrl;
  logic [2:0]  state_o;
  logic        busy_o, mem_timeout_o;
  logic [31:0] retired_o;
  logic [4:0]  en;

  int checks = 0;
  int failures = 0;

  mc_ctrl_fsm #(.RETIRE_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .alusel(alusel), .stall_i(stall_i),
    .mem_ready_i(mem_ready_i), .halt_req_i(halt_req_i),
    .pc_en(pc_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .jump_en(jump_en), .imm_en(imm_en), .expc_en(expc_en), .l_or_s(l_or_s),
    .wb_ctrl(wb_ctrl), .state_o(state_o), .busy_o(busy_o),
    .mem_timeout_o(mem_timeout_o), .retired_o(retired_o)
  );

  assign en = {pc_en, id_en, ex_en, mem_en, wb_en};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_i = 1'b0; mem_ready_i = 1'b0; halt_req_i = 1'b0; alusel = 7'b0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; mem_ready_i = 1'b1; halt_req_i = 1'b0; alusel = 7'b1111111;
    repeat (6) adv();
    do_reset();
    #1;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (en !== 5'b10000) begin failures++; $display("FAIL reset_en got=%b exp=10000", en); end
    checks++; if (retired_o !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired_o); end
    checks++; if ({jump_en, imm_en, expc_en, l_or_s, wb_ctrl, mem_timeout_o} !== 7'b0)
      begin failures++; $display("FAIL reset_side got=%b exp=0000000", {jump_en, imm_en, expc_en, l_or_s, wb_ctrl, mem_timeout_o}); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    logic [4:0] exp_en [5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00001, 5'b10000};
    do_reset();
    alusel = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adv();
      #1;
      checks++; if (en !== exp_en[i]) begin failures++; $display("FAIL alu_en cyc%0d got=%b exp=%b", i, en, exp_en[i]); end
    end
    checks++; if (wb_ctrl !== 2'b01) begin failures++; $display("FAIL alu_wb_ctrl got=%b exp=01", wb_ctrl); end
    checks++; if (expc_en !== 1'b1) begin failures++; $display("FAIL alu_expc got=%b exp=1", expc_en); end
    checks++; if (retired_o !== 32'd1) begin failures++; $display("FAIL alu_retired got=%0d exp=1", retired_o); end
    $display("test_alu: alusel=0000011 retired=%0d", retired_o);
  endtask

  task automatic test_load();
    logic [4:0] exp_en [8] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010,
                               5'b00010, 5'b00010, 5'b00001, 5'b10000};
    do_reset();
    alusel = 7'b0001001;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) adv();
      mem_ready_i = (i == 5);
      #1;
      checks++; if (en !== exp_en[i]) begin failures++; $display("FAIL load_en cyc%0d got=%b exp=%b", i, en, exp_en[i]); end
    end
    checks++; if (l_or_s !== 1'b0) begin failures++; $display("FAIL load_l_or_s got=%b exp=0", l_or_s); end
    checks++; if (retired_o !== 32'd1) begin failures++; $display("FAIL load_retired got=%0d exp=1", retired_o); end
    $display("test_load: alusel=0001001 retired=%0d", retired_o);
  endtask

  task automatic test_store();
    logic [4:0] exp_en [5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b10000};
    do_reset();
    alusel = 7'b0011001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adv();
      mem_ready_i = (i == 3);
      #1;
      checks++; if (en !== exp_en[i]) begin failures++; $display("FAIL store_en cyc%0d got=%b exp=%b", i, en, exp_en[i]); end
      if (i == 3) begin
        checks++; if (l_or_s !== 1'b1) begin failures++; $display("FAIL store_l_or_s got=%b exp=1", l_or_s); end
      end
    end
    mem_ready_i = 1'b0;
    checks++; if (retired_o !== 32'd1) begin failures++; $display("FAIL store_retired got=%0d exp=1", retired_o); end
    $display("test_store: alusel=0011001 retired=%0d", retired_o);
  endtask

  task automatic test_timeout();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
    do_reset();
    alusel = 7'b0001001;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) adv();
      #1;
      checks++; if (state_o !== exp_st[i]) begin failures++; $display("FAIL timeout_state cyc%0d got=%0d exp=%0d", i, state_o, exp_st[i]); end
    end
    checks++; if (mem_timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", mem_timeout_o); end
    checks++; if ({busy_o, en} !== 6'b0) begin failures++; $display("FAIL timeout_halt_outs got=%b exp=000000", {busy_o, en}); end
    repeat (3) adv();
    checks++; if (state_o !== 3'd5) begin failures++; $display("FAIL timeout_sticky got=%0d exp=5", state_o); end
    checks++; if (retired_o !== 32'd0) begin failures++; $display("FAIL timeout_retired got=%0d exp=0", retired_o); end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    checks++; if ({state_o, mem_timeout_o, en} !== {3'd0, 1'b0, 5'b10000})
      begin failures++; $display("FAIL timeout_rst got=%b exp=%b", {state_o, mem_timeout_o, en}, {3'd0, 1'b0, 5'b10000}); end
    $display("test_timeout: halted after 4 MEM cycles, cleared by rst");
  endtask

  task automatic test_stall();
    logic [4:0] exp_en [7] = '{5'b10000, 5'b01000, 5'b00000, 5'b00000, 5'b00100, 5'b00001, 5'b10000};
    logic [2:0] exp_st [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd0};
    do_reset();
    alusel = 7'b0000011;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) adv();
      stall_i = (i == 2 || i == 3);
      #1;
      checks++; if (en !== exp_en[i]) begin failures++; $display("FAIL stall_en cyc%0d got=%b exp=%b", i, en, exp_en[i]); end
      checks++; if (state_o !== exp_st[i]) begin failures++; $display("FAIL stall_state cyc%0d got=%0d exp=%0d", i, state_o, exp_st[i]); end
    end
    checks++; if (retired_o !== 32'd1) begin failures++; $display("FAIL stall_retired got=%0d exp=1", retired_o); end
    $display("test_stall: ALU op with 2 stall cycles retired=%0d", retired_o);
  endtask

  task automatic test_halt();
    do_reset();
    halt_req_i = 1'b1;
    #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL halt_pc_en got=%b exp=00000", en); end
    adv();
    checks++; if ({state_o, busy_o} !== {3'd5, 1'b0}) begin failures++; $display("FAIL halt_enter got=%b exp=1010", {state_o, busy_o}); end
    adv();
    halt_req_i = 1'b0;
    #1;
    checks++; if (state_o !== 3'd5) begin failures++; $display("FAIL halt_hold got=%0d exp=5", state_o); end
    adv();
    checks++; if ({state_o, busy_o, en} !== {3'd0, 1'b1, 5'b10000})
      begin failures++; $display("FAIL halt_exit got=%b exp=%b", {state_o, busy_o, en}, {3'd0, 1'b1, 5'b10000}); end
    checks++; if (retired_o !== 32'd0) begin failures++; $display("FAIL halt_retired got=%0d exp=0", retired_o); end
    $display("test_halt: enter and exit");
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    do_reset();
    alusel = 7'b1100000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) adv();
      if (i == 3) alusel = 7'b0000101;
      #1;
      checks++; if (state_o !== exp_st[i]) begin failures++; $display("FAIL b2b_state cyc%0d got=%0d exp=%0d", i, state_o, exp_st[i]); end
      case (i)
        1: begin checks++; if (jump_en !== 1'b1) begin failures++; $display("FAIL b2b_jump1 got=%b exp=1", jump_en); end end
        3: begin checks++; if ({imm_en, expc_en, retired_o} !== {2'b10, 32'd1})
             begin failures++; $display("FAIL b2b_op1 imm/expc/ret got=%b/%b/%0d exp=1/0/1", imm_en, expc_en, retired_o); end end
        4: begin checks++; if (jump_en !== 1'b0) begin failures++; $display("FAIL b2b_jump2 got=%b exp=0", jump_en); end end
        6: begin checks++; if (wb_ctrl !== 2'b10) begin failures++; $display("FAIL b2b_wb_ctrl got=%b exp=10", wb_ctrl); end end
        7: begin checks++; if ({imm_en, retired_o} !== {1'b0, 32'd2})
             begin failures++; $display("FAIL b2b_op2 imm/ret got=%b/%0d exp=0/2", imm_en, retired_o); end end
        default: ;
      endcase
    end
    $display("test_back_to_back: branch then ALU, retired=%0d", retired_o);
  endtask

  task automatic test_rst_mid_mem();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
    do_reset();
    alusel = 7'b0000011;
    repeat (4) adv();
    alusel = 7'b0001001;
    repeat (4) adv();
    #1;
    checks++; if ({state_o, retired_o} !== {3'd3, 32'd1}) begin failures++; $display("FAIL rmm_pre state/ret got=%0d/%0d exp=3/1", state_o, retired_o); end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    checks++; if ({state_o, retired_o} !== {3'd0, 32'd0}) begin failures++; $display("FAIL rmm_post state/ret got=%0d/%0d exp=0/0", state_o, retired_o); end
    for (int i = 1; i < 8; i++) begin
      adv();
      checks++; if (state_o !== exp_st[i]) begin failures++; $display("FAIL rmm_state cyc%0d got=%0d exp=%0d", i, state_o, exp_st[i]); end
    end
    $display("test_rst_mid_mem: reset during MEM recovered");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_stall();
    test_halt();
    test_back_to_back();
    test_rst_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
